alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised WIDTH-bit ALU that succeeds the 1-bit ripple ALU slice in the datapath. It keeps the MIPS-style operation set (AND/OR/ADD/SUB/SLT/NOR, built on the Ainvert/Binvert + carry-in scheme) and adds registered status flags and an iterative shift-and-add multiply. It has valid/ready handshakes on both the input and output sides. It sits between the register-file read stage and writeback, and stalls the upstream stage while a multiply is in progress.

## Interface
- WIDTH, 32, operand/result width (≥ 2)
- MUL_EN, 1, 1 enables the multiply opcode; 0 makes it illegal
- clk  input  1  rising-edge clock, single domain
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  4  operation select
- out_valid  output  1  result/flags valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- carry  output  1  adder carry-out
- overflow  output  1  signed overflow (ADD/SUB) / product truncation (MUL)
- err  output  1  illegal opcode flagged

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a + ~b + 1), 0111 SLT, 1100 NOR (~a & ~b).
  - 1000 MUL: unsigned, low WIDTH bits of a*b.
  - Any other code, or 1000 when MUL_EN=0, is illegal.
- Adder flags:
  - carry = adder MSB carry-out for ADD/SUB/SLT; for SUB, carry=1 means no borrow.
  - overflow = carry into MSB xor carry out of MSB, for ADD/SUB.
- SLT:
  - result = {WIDTH-1 zeros, sum[MSB] xor overflow}, so it is correct across signed overflow.
  - carry is from the subtraction; overflow is reported 0.
- Logic ops: carry = overflow = 0.
- MUL:
  - carry = 0.
  - overflow = 1 iff any of the upper WIDTH product bits is nonzero.
- Illegal opcode: result = 0, carry = overflow = 0, zero = 1, err = 1. It completes with single-cycle latency.
- zero is always computed from the registered result.
- FSM states:
  - IDLE: in_ready = 1. On accept, a single-cycle op goes to DONE with outputs loaded; MUL goes to MULT, loading multiplicand = a, multiplier = b, acc = 0 (2·WIDTH bits), cnt = 0.
  - MULT: each cycle, if multiplier[0] then acc += multiplicand << cnt; multiplier >>= 1; cnt++. After WIDTH iterations, go to DONE with result = acc[WIDTH-1:0].
  - DONE: out_valid = 1 and outputs held stable. On out_ready, the result is consumed. If in_valid is high in the same cycle it is accepted (back-to-back); otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 in MULT and while rst_n is low.
- Operands and op are sampled only on the accepting edge. Input changes at any other time are ignored.

## Timing
- Reset (rst_n low at a rising edge):
  - state → IDLE.
  - result, zero, carry, overflow, err, out_valid = 0; in_ready = 0 while rst_n is low.
- In the first cycle after rst_n returns high, in_ready = 1.
- Latency from the accepting edge to out_valid high:
  - Single-cycle ops and illegal ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Throughput: single-cycle ops sustain 1 per cycle when out_ready is held high.
- Backpressure: out_valid stays high and result/flags stay frozen until out_ready is high at an edge.
- Reset asserted during MULT or DONE aborts the operation: no out_valid, and the partial result is discarded.
- out_valid never deasserts without out_ready, except on reset.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Reset: hold rst_n low for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, all flags 0; one cycle after release, in_ready=1.
- ADD/SUB flags:
  - ADD 0x7F+0x01 → result 0x80, overflow=1, carry=0, zero=0.
  - ADD 0xFF+0x01 → result 0x00, carry=1, zero=1, overflow=0.
  - SUB 0x05−0x05 → result 0x00, zero=1, carry=1.
- SLT and NOR:
  - SLT a=0x80, b=0x7F → result 0x01 despite overflow.
  - SLT 0x03, 0x02 → 0x00.
  - NOR 0xF0, 0x0C → 0x03.
- MUL with backpressure:
  - MUL 0x0D×0x0B → result 0x8F, overflow=0, out_valid exactly 9 cycles after accept, in_ready=0 in between.
  - MUL 0x10×0x10 → 0x00, overflow=1, zero=1.
  - Hold out_ready=0 for 4 cycles → outputs stable.
- Back-to-back and illegal:
  - Stream ADD, AND, OR with out_ready=1 → one result per cycle in order.
  - op=1111 → err=1, result 0.
  - With MUL_EN=0, op=1000 → err=1.
- Reset mid-multiply: assert rst_n low at cycle 4 of MULT → no out_valid; the next ADD 0x02+0x03 returns 0x05 with correct latency.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit MIPS-style ALU with registered flags,
// iterative shift-and-add multiply and valid/ready handshakes.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   ax, bx;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic               c_msb;
  logic               add_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_err, is_mul;
  logic [2*WIDTH-1:0] acc_nx;
  logic               accept;

  // Single-cycle datapath: Ainvert/Binvert + carry-in adder and logic ops
  always_comb begin
    ax      = op[3] ? ~a : a;
    bx      = op[2] ? ~b : b;
    cin     = op[2];
    sum     = {1'b0, ax} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    c_msb   = ax[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1];
    add_v   = c_msb ^ sum[WIDTH];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    unique case (op)
      4'b0000: alu_res = ax & bx;
      4'b0001: alu_res = ax | bx;
      4'b0010, 4'b0110: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_v;
      end
      4'b0111: begin
        alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_v};
        alu_c   = sum[WIDTH];
      end
      4'b1100: alu_res = ax & bx;
      4'b1000: begin
        is_mul  = MUL_EN;
        alu_err = !MUL_EN;
      end
      default: alu_err = 1'b1;
    endcase
  end

  // Handshake, multiply step and next-state logic
  always_comb begin
    out_valid  = (state_q == DONE);
    in_ready   = rst_n && ((state_q == IDLE) ||
                           ((state_q == DONE) && out_ready));
    accept     = in_valid && in_ready;
    acc_nx     = acc_q + (mplier_q[0] ? mcand_q : '0);
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) state_d = IDLE;
        if (accept) begin
          if (is_mul) begin
            state_d  = MULT;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d    = DONE;
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            carry_d    = alu_c;
            overflow_d = alu_v;
            err_d      = alu_err;
          end
        end
      end
      MULT: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          result_d   = acc_nx[WIDTH-1:0];
          zero_d     = (acc_nx[WIDTH-1:0] == '0);
          carry_d    = 1'b0;
          overflow_d = |acc_nx[2*WIDTH-1:WIDTH];
          err_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8),
// plus a MUL_EN=0 instance for the illegal-multiply case.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       zero, carry, overflow, err;

  logic       n_in_ready, n_out_valid;
  logic [7:0] n_result;
  logic       n_zero, n_carry, n_overflow, n_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    string      tag;
    logic [11:0] exp;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  bit   seen = 1'b0;
  bit   hold = 1'b0;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .err(err)
  );

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(n_out_valid), .out_ready(1'b1),
    .result(n_result), .zero(n_zero), .carry(n_carry),
    .overflow(n_overflow), .err(n_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // {err, overflow, carry, zero, result[7:0]}
  function automatic logic [11:0] fl(logic e, logic v, logic c,
                                     logic z, logic [7:0] r);
    return {e, v, c, z, r};
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic send(string tag, logic [3:0] o, logic [7:0] x,
                      logic [7:0] y, logic [11:0] e, int lat);
    int n = 0;
    int t;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk({tag, "_accept"}, 32'(0), 32'(1));
      in_valid = 1'b0;
      return;
    end
    t = cyc;
    @(posedge clk);
    #1;
    sb.push_back('{tag, e, lat, t});
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'(0));
    @(negedge clk);
  endtask

  // Output monitor: compare head of scoreboard, latency and stability
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
      hold = 1'b0;
    end else begin
      if (hold && !out_valid) chk("drop", 32'(0), 32'(1));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious", 32'(1), 32'(0));
        end else begin
          chk(sb[0].tag,
              32'(fl(err, overflow, carry, zero, result)),
              32'(sb[0].exp));
          if (!seen) begin
            chk({sb[0].tag, "_lat"}, 32'(cyc - sb[0].acc),
                32'(sb[0].lat));
            seen = 1'b1;
          end
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
      hold = out_valid && !out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    bit any;
    int n;

    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_flags",
          32'(fl(err, overflow, carry, zero, result)), 32'(0));
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'(1));

    send("add_7f_01", 4'b0010, 8'h7F, 8'h01, fl(0, 1, 0, 0, 8'h80), 1);
    send("add_ff_01", 4'b0010, 8'hFF, 8'h01, fl(0, 0, 1, 1, 8'h00), 1);
    send("sub_05_05", 4'b0110, 8'h05, 8'h05, fl(0, 0, 1, 1, 8'h00), 1);
    send("slt_80_7f", 4'b0111, 8'h80, 8'h7F, fl(0, 0, 1, 0, 8'h01), 1);
    send("slt_03_02", 4'b0111, 8'h03, 8'h02, fl(0, 0, 1, 1, 8'h00), 1);
    send("nor_f0_0c", 4'b1100, 8'hF0, 8'h0C, fl(0, 0, 0, 0, 8'h03), 1);
    drain();

    send("mul_0d_0b", 4'b1000, 8'h0D, 8'h0B, fl(0, 0, 0, 0, 8'h8F), 9);
    chk("nomul_illegal",
        32'({n_out_valid, fl(n_err, n_overflow, n_carry, n_zero, n_result)}),
        32'({1'b1, fl(1, 0, 0, 1, 8'h00)}));
    chk("mul_busy", 32'(in_ready), 32'(0));
    repeat (7) begin
      @(negedge clk);
      chk("mul_busy", 32'(in_ready), 32'(0));
    end
    drain();

    out_ready = 1'b0;
    send("mul_10_10", 4'b1000, 8'h10, 8'h10, fl(0, 1, 0, 1, 8'h00), 9);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(out_valid), 32'(1));
    repeat (4) @(negedge clk);
    chk("bp_held", 32'({in_ready, out_valid}), 32'({1'b0, 1'b1}));
    out_ready = 1'b1;
    drain();

    t0 = cyc;
    send("str_add", 4'b0010, 8'h12, 8'h34, fl(0, 0, 0, 0, 8'h46), 1);
    send("str_and", 4'b0000, 8'hF0, 8'h3C, fl(0, 0, 0, 0, 8'h30), 1);
    send("str_or", 4'b0001, 8'h0F, 8'h30, fl(0, 0, 0, 0, 8'h3F), 1);
    send("illegal", 4'b1111, 8'hAA, 8'h55, fl(1, 0, 0, 1, 8'h00), 1);
    chk("stream_rate", 32'(cyc - t0), 32'(4));
    drain();

    send("mul_abort", 4'b1000, 8'h0D, 8'h0B, fl(0, 0, 0, 0, 8'h8F), 9);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    any = 1'b0;
    repeat (12) begin
      @(negedge clk);
      any |= out_valid;
    end
    chk("abort_no_valid", 32'(any), 32'(0));
    send("add_after", 4'b0010, 8'h02, 8'h03, fl(0, 0, 0, 0, 8'h05), 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
